sram_fifo_ctrl: RTL and testbench

Byte-stream FIFO controller that sits directly upstream of the single-port 8x64 OpenRAM macro (`sram_8_64_freepdk45`) and uses it as FIFO storage. It accepts bytes on a valid/ready input, writes them into the SRAM, reads them back in order, and presents them on a valid/ready output. A 2-entry output queue absorbs the SRAM read latency. Only one SRAM access (read or write) is issued per cycle.

---
 rtl/sram_fifo_pkg.sv | 11 +
 rtl/sram_fifo_outq.sv | 39 +++
 rtl/sram_fifo_ctrl.sv | 107 ++++++++++
 tb/tb_sram_fifo_ctrl.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: shared sizing constants for the SRAM-backed byte FIFO.
// DATA_WIDTH/ADDR_WIDTH match the 8x64 macro; DEPTH is derived.
package sram_fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 6;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int CNT_WIDTH  = ADDR_WIDTH + 1;
    localparam int OQ_DEPTH   = 2;

endpackage

// File: rtl/sram_fifo_outq.sv
// sram_fifo_outq: 2-entry output queue absorbing the SRAM read latency.
// Ports: clk0/rst0 (sync, active high), i_push/i_data, i_pop, o_data (head), o_cnt.
module sram_fifo_outq
    import sram_fifo_pkg::*;
(
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_cnt
);

    logic [DATA_WIDTH-1:0] r_mem [OQ_DEPTH];
    logic                  r_head;
    logic [1:0]            r_cnt;
    logic                  w_tail;

    // With two entries the tail is the head when empty, the other slot otherwise.
    assign w_tail = r_head ^ r_cnt[0];

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (i_push) r_mem[w_tail] <= i_data;
            if (i_pop)  r_head <= ~r_head;
            r_cnt <= r_cnt + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_data = r_mem[r_head];
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: byte FIFO using the single-port 8x64 SRAM macro as storage.
// Ports: clk0, rst0 (sync, active high); in_valid/in_ready/in_data input stream;
// out_valid/out_ready/out_data output stream; level = bytes held (0..DEPTH+2);
// sram_csb0/web0/addr0/din0 drive the macro, sram_dout0 returns read data.
// Option: define FIFO_CTRL_BYPASS_EN to route bytes straight into the output
// queue when the SRAM path is empty (1-cycle latency instead of 3).
module sram_fifo_ctrl
    import sram_fifo_pkg::*;
(
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  level,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [CNT_WIDTH-1:0]  r_sram_cnt;
    logic                  r_rd_inflight;

    logic [1:0]            w_oq_cnt;
    logic                  w_rd_issue;
    logic                  w_acc;
    logic                  w_byp;
    logic                  w_wr;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_push_data;

    // Reads depend only on registered state and win the port over writes;
    // the occupancy test keeps the output queue from ever overflowing.
    assign w_rd_issue = !rst0 && (r_sram_cnt != '0)
                      && (({1'b0, w_oq_cnt} + {2'b0, r_rd_inflight}) < 3'd2);

    assign in_ready = !rst0 && (r_sram_cnt != CNT_WIDTH'(DEPTH)) && !w_rd_issue;
    assign w_acc    = in_valid && in_ready;

`ifdef FIFO_CTRL_BYPASS_EN
    // Only safe while nothing older sits in the SRAM or in flight.
    assign w_byp = w_acc && (r_sram_cnt == '0) && !r_rd_inflight
                 && (w_oq_cnt < 2'(OQ_DEPTH));
`else
    assign w_byp = 1'b0;
`endif

    assign w_wr = w_acc && !w_byp;

    // Read data lands one cycle after issue; bypass never overlaps it.
    assign w_push      = r_rd_inflight || w_byp;
    assign w_push_data = r_rd_inflight ? sram_dout0 : in_data;
    assign out_valid   = (w_oq_cnt != 2'd0);
    assign w_pop       = out_valid && out_ready;

    assign sram_csb0  = !(w_rd_issue || w_wr);
    assign sram_web0  = !w_wr;
    assign sram_addr0 = rst0       ? '0
                      : w_rd_issue ? r_rd_ptr
                      : w_wr       ? r_wr_ptr
                      :              r_addr;
    assign sram_din0  = rst0 ? '0 : (w_wr ? in_data : r_din);

    always_ff @(posedge clk0) begin
        if (rst0) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_addr        <= '0;
            r_din         <= '0;
            r_sram_cnt    <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            if (w_wr)       r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_sram_cnt    <= r_sram_cnt + {{ADDR_WIDTH{1'b0}}, w_wr}
                                        - {{ADDR_WIDTH{1'b0}}, w_rd_issue};
            r_rd_inflight <= w_rd_issue;
            r_addr        <= sram_addr0;
            r_din         <= sram_din0;
        end
    end

    sram_fifo_outq u_outq (
        .clk0   (clk0),
        .rst0   (rst0),
        .i_push (w_push),
        .i_data (w_push_data),
        .i_pop  (w_pop),
        .o_data (out_data),
        .o_cnt  (w_oq_cnt)
    );

    assign level = r_sram_cnt
                 + {{ADDR_WIDTH{1'b0}}, r_rd_inflight}
                 + {{(CNT_WIDTH-2){1'b0}}, w_oq_cnt};

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: self-checking bench for sram_fifo_ctrl with a
// behavioural model of the 8x64 macro (inputs at rise, update at fall).
module sram_8_64_freepdk45 (
    input  logic       clk0,
    input  logic       csb0,
    input  logic       web0,
    input  logic [5:0] addr0,
    input  logic [7:0] din0,
    output logic [7:0] dout0
);
    logic [7:0] mem [64];
    logic       csb_r;
    logic       web_r;
    logic [5:0] addr_r;
    logic [7:0] din_r;

    always @(posedge clk0) begin
        csb_r  <= csb0;
        web_r  <= web0;
        addr_r <= addr0;
        din_r  <= din0;
    end

    always @(negedge clk0) begin
        if (!csb_r && !web_r) mem[addr_r] <= din_r;
        if (!csb_r && web_r)  dout0 <= mem[addr_r];
    end
endmodule

module tb_sram_fifo_ctrl;
    import sram_fifo_pkg::*;

`ifdef FIFO_CTRL_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic       clk0 = 1'b0;
    logic       rst0;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [6:0] level;
    logic       sram_csb0;
    logic       sram_web0;
    logic [5:0] sram_addr0;
    logic [7:0] sram_din0;
    logic [7:0] sram_dout0;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q [$];
    logic [7:0] e;

    always #5 clk0 = ~clk0;

    sram_fifo_ctrl dut (
        .clk0       (clk0),
        .rst0       (rst0),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
    );

    sram_8_64_freepdk45 u_mem (
        .clk0  (clk0),
        .csb0  (sram_csb0),
        .web0  (sram_web0),
        .addr0 (sram_addr0),
        .din0  (sram_din0),
        .dout0 (sram_dout0)
    );

    task automatic nxt();
        @(posedge clk0);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; in_valid = 1'b1; in_data = 8'h11; out_ready = 1'b0;
        nxt();
        @(negedge clk0);
        n_vec++;
        if ({in_ready, out_valid, level, sram_csb0, sram_web0} !== {2'b00, 7'd0, 2'b11}) begin
            n_err++;
            $display("FAIL reset_outs: rdy/ov/lvl/csb/web got %b %b %0d %b %b, required 0 0 0 1 1",
                     in_ready, out_valid, level, sram_csb0, sram_web0);
        end
        n_vec++;
        if ({sram_addr0, sram_din0, out_data} !== 22'd0) begin
            n_err++;
            $display("FAIL reset_bus: addr/din/dout got %0h %0h %0h, required 0 0 0",
                     sram_addr0, sram_din0, out_data);
        end
        nxt();
        rst0 = 1'b0; in_valid = 1'b0;
        @(negedge clk0);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b, required 1", in_ready);
        end
        nxt();
    endtask

    task automatic test_single();
        int got;
        got = -1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        @(negedge clk0);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL single_accept: in_ready got %b, required 1", in_ready);
        end else exp_q.push_back(in_data);
        nxt();
        in_valid = 1'b0;
        for (int c = 1; c <= 10 && got < 0; c++) begin
            @(negedge clk0);
            if (c == 1) begin
                n_vec++;
                if (level !== 7'd1) begin
                    n_err++;
                    $display("FAIL single_level_hold: got %0d, required 1", level);
                end
            end
            if (out_valid) begin
                got = c;
                n_vec++;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL single_data: got %0h, required %0h", out_data, e);
                end
            end
            nxt();
        end
        n_vec++;
        if (got != LAT) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles, required %0d", got, LAT);
        end
        @(negedge clk0);
        n_vec++;
        if (level !== 7'd0) begin
            n_err++;
            $display("FAIL single_level_empty: got %0d, required 0", level);
        end
        nxt();
    endtask

    task automatic test_fill();
        bit acc;
        int drained;
        out_ready = 1'b0;
        for (int i = 0; i < 66; i++) begin
            in_valid = 1'b1; in_data = 8'(i); acc = 1'b0;
            for (int c = 0; c < 10 && !acc; c++) begin
                @(negedge clk0);
                if (in_ready) begin
                    acc = 1'b1;
                    exp_q.push_back(in_data);
                end
                nxt();
            end
            if (!acc) begin
                n_vec++; n_err++;
                $display("FAIL fill_accept: byte %0d not accepted, required accept", i);
            end
        end
        in_data = 8'h42;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk0);
            n_vec++;
            if (in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL fill_full_ready: got %b, required 0", in_ready);
            end
            nxt();
        end
        @(negedge clk0);
        n_vec++;
        if (level !== 7'd66 || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL fill_level: level/ov got %0d %b, required 66 1", level, out_valid);
        end
        nxt();
        in_valid = 1'b0; out_ready = 1'b1; drained = 0;
        for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
            @(negedge clk0);
            if (out_valid) begin
                n_vec++;
                e = exp_q.pop_front();
                drained++;
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL fill_drain_data: got %0h, required %0h", out_data, e);
                end
            end
            nxt();
        end
        @(negedge clk0);
        n_vec++;
        if (drained != 66 || level !== 7'd0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fill_drain_end: drained/level/ov got %0d %0d %b, required 66 0 0",
                     drained, level, out_valid);
        end
        exp_q.delete();
        nxt();
    endtask

    task automatic test_wrap();
        int         sent;
        int         rcv;
        int         wr_n;
        int         rd_n;
        logic [5:0] m_wa;
        logic [5:0] m_ra;
        sent = 0; rcv = 0; wr_n = 0; rd_n = 0; m_wa = 6'd0; m_ra = 6'd0;
        rst0 = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        nxt();
        rst0 = 1'b0; exp_q.delete();
        in_valid = 1'b1; in_data = 8'd0;
        for (int c = 0; c < 2000 && rcv < 200; c++) begin
            @(negedge clk0);
            if (!sram_csb0) begin
                n_vec++;
                if (!sram_web0) begin
                    if (sram_addr0 !== m_wa || sram_din0 !== in_data) begin
                        n_err++;
                        $display("FAIL wrap_wr_addr: addr/din got %0d %0h, required %0d %0h",
                                 sram_addr0, sram_din0, m_wa, in_data);
                    end
                    m_wa++; wr_n++;
                end else begin
                    if (sram_addr0 !== m_ra) begin
                        n_err++;
                        $display("FAIL wrap_rd_addr: got %0d, required %0d", sram_addr0, m_ra);
                    end
                    m_ra++; rd_n++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                sent++;
            end
            if (out_valid) begin
                n_vec++;
                rcv++;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL wrap_data: got %0h, required %0h", out_data, e);
                end
            end
            nxt();
            in_valid = (sent < 200);
            in_data  = 8'(sent);
        end
        in_valid = 1'b0;
        n_vec++;
        if (rcv != 200 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL wrap_count: received %0d left %0d, required 200 0", rcv, exp_q.size());
        end
`ifndef FIFO_CTRL_BYPASS_EN
        n_vec++;
        if (wr_n != 200 || rd_n != 200) begin
            n_err++;
            $display("FAIL wrap_sram_ops: writes/reads got %0d %0d, required 200 200", wr_n, rd_n);
        end
`endif
        for (int c = 0; c < 4; c++) nxt();
    endtask

    task automatic test_arb();
        int drained;
        drained = 0;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h31;
        @(negedge clk0);
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL arb_first: in_ready got %b, required 1", in_ready);
        end else exp_q.push_back(in_data);
        nxt();
        in_data = 8'h32;
        @(negedge clk0);
        n_vec++;
        if ({in_ready, sram_csb0, sram_web0} !== 3'b001) begin
            n_err++;
            $display("FAIL arb_read_wins: rdy/csb/web got %b %b %b, required 0 0 1",
                     in_ready, sram_csb0, sram_web0);
        end
        if (in_ready) exp_q.push_back(in_data);
        nxt();
        @(negedge clk0);
        n_vec++;
        if ({in_ready, sram_csb0, sram_web0} !== 3'b100) begin
            n_err++;
            $display("FAIL arb_retry: rdy/csb/web got %b %b %b, required 1 0 0",
                     in_ready, sram_csb0, sram_web0);
        end
        if (in_ready) exp_q.push_back(in_data);
        nxt();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk0);
            if (out_valid) begin
                n_vec++;
                drained++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL arb_data: got %0h, required %0h", out_data, e);
                end
            end
            nxt();
        end
        @(negedge clk0);
        n_vec++;
        if (drained != 2 || level !== 7'd0) begin
            n_err++;
            $display("FAIL arb_count: drained/level got %0d %0d, required 2 0", drained, level);
        end
        exp_q.delete();
        nxt();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h71 + 8'(i);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk0);
                if (in_ready) begin
                    exp_q.push_back(in_data);
                    nxt();
                    break;
                end
                nxt();
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) nxt();
        out_ready = 1'b1;
        @(negedge clk0);
        n_vec++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (out_valid !== 1'b1 || out_data !== e) begin
            n_err++;
            $display("FAIL midrst_pop: ov/data got %b %0h, required 1 %0h", out_valid, out_data, e);
        end
        nxt();
        out_ready = 1'b0;
        @(negedge clk0);
        n_vec++;
        if ({sram_csb0, sram_web0} !== 2'b01) begin
            n_err++;
            $display("FAIL midrst_issue: csb/web got %b %b, required 0 1", sram_csb0, sram_web0);
        end
        nxt();
        rst0 = 1'b1;
        nxt();
        rst0 = 1'b0; out_ready = 1'b1; exp_q.delete();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk0);
            n_vec++;
            if (out_valid !== 1'b0 || level !== 7'd0) begin
                n_err++;
                $display("FAIL midrst_flushed: ov/level got %b %0d, required 0 0", out_valid, level);
            end
            nxt();
        end
    endtask

    initial begin
        rst0 = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_fill();
        test_wrap();
`ifndef FIFO_CTRL_BYPASS_EN
        test_arb();
`endif
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
